// File: rtl/j1_irq_ctrl.sv
// j1_irq_ctrl: prioritising interrupt controller for the j1 core, IO-mapped at BASE.
// Ports: clk, resetq (async low), irq_src[NSRC], io_rd/io_wr/io_addr/io_wdata in,
//        io_rdata (0 when not selected), interrupt_request (registered).
module j1_irq_ctrl #(
    parameter int          NSRC = 8,
    parameter int          SYNC = 2,
    parameter logic [15:0] BASE = 16'h0100
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [NSRC-1:0] irq_src,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     io_addr,
    input  logic [15:0]     io_wdata,
    output logic [15:0]     io_rdata,
    output logic            interrupt_request
);

    logic [NSRC-1:0] sync_q [SYNC];
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_nxt;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] edge_mode;

    logic            sel;
    logic [2:0]      rsel;
    logic [NSRC-1:0] wbits;
    logic            wr_pend;
    logic            wr_en;
    logic            wr_edge;
    logic            wr_force;
    logic            rd_cause;

    logic [NSRC-1:0] pe;
    logic [NSRC-1:0] cause_onehot;
    logic [3:0]      cause_idx;
    logic            cause_valid;
    logic [NSRC-1:0] ack;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] force_set;
    logic [NSRC-1:0] to_edge;
    logic [15:0]     rdata_mux;
    logic            unused_bits;

    assign unused_bits = ^{io_addr[0], io_wdata};

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s    = sync_q[SYNC-1];
    assign rise = s & ~prev;

    assign sel      = (io_rd | io_wr) && (io_addr[15:4] == BASE[15:4]);
    assign rsel     = io_addr[3:1];
    assign wbits    = io_wdata[NSRC-1:0];
    assign wr_pend  = io_wr && sel && (rsel == 3'd0);
    assign wr_en    = io_wr && sel && (rsel == 3'd1);
    assign wr_edge  = io_wr && sel && (rsel == 3'd2);
    assign wr_force = io_wr && sel && (rsel == 3'd4);
    assign rd_cause = io_rd && sel && (rsel == 3'd3);

    // Lowest index of PENDING & ENABLE wins.
    always_comb begin
        pe           = pending & enable;
        cause_onehot = '0;
        cause_idx    = '0;
        cause_valid  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (pe[i] && !cause_valid) begin
                cause_valid     = 1'b1;
                cause_onehot[i] = 1'b1;
                cause_idx       = 4'(i);
            end
        end
    end

    assign ack       = (rd_cause ? cause_onehot : '0) & edge_mode;
    assign w1c       = wr_pend ? wbits : '0;
    assign force_set = wr_force ? wbits : '0;
    // Bits switching level->edge this cycle keep their pending value.
    assign to_edge   = wr_edge ? (wbits & ~edge_mode) : '0;

    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < NSRC; i++) begin
            if (to_edge[i])
                pending_nxt[i] = pending[i];
            else if (!edge_mode[i])
                pending_nxt[i] = s[i];
            else if (rise[i] || force_set[i])
                pending_nxt[i] = 1'b1;
            else if (w1c[i] || ack[i])
                pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prev              <= '0;
            pending           <= '0;
            enable            <= '0;
            edge_mode         <= '0;
            interrupt_request <= 1'b0;
        end else begin
            prev              <= s;
            pending           <= pending_nxt;
            interrupt_request <= |(pending & enable);
            if (wr_en)   enable    <= wbits;
            if (wr_edge) edge_mode <= wbits;
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (rsel)
            3'd0:    rdata_mux = 16'(pending);
            3'd1:    rdata_mux = 16'(enable);
            3'd2:    rdata_mux = 16'(edge_mode);
            3'd3:    rdata_mux = {cause_valid, 11'b0, cause_idx};
            default: rdata_mux = '0;
        endcase
    end

    assign io_rdata = (io_rd && sel) ? rdata_mux : 16'h0000;

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// tb_j1_irq_ctrl: directed table plus multi-cycle sequences for j1_irq_ctrl.
// Inputs change on negedge; outputs are sampled away from posedge.
module tb_j1_irq_ctrl;

    localparam logic [15:0] A_PEND  = 16'h0100;
    localparam logic [15:0] A_EN    = 16'h0102;
    localparam logic [15:0] A_EDGE  = 16'h0104;
    localparam logic [15:0] A_CAUSE = 16'h0106;
    localparam logic [15:0] A_FORCE = 16'h0108;

    logic        clk = 1'b0;
    logic        resetq;
    logic [7:0]  irq_src;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        interrupt_request;

    int checks = 0;
    int errors = 0;

    j1_irq_ctrl #(.NSRC(8), .SYNC(2), .BASE(16'h0100)) dut (
        .clk               (clk),
        .resetq            (resetq),
        .irq_src           (irq_src),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_wdata          (io_wdata),
        .io_rdata          (io_rdata),
        .interrupt_request (interrupt_request)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; the access spans the next posedge.
    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        io_wr    = 1'b1;
        io_addr  = a;
        io_wdata = d;
        @(negedge clk);
        io_wr    = 1'b0;
        io_wdata = 16'h0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        io_rd   = 1'b1;
        io_addr = a;
        #1 d = io_rdata;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a,
                          input logic [15:0] exp);
        logic [15:0] d;
        io_read(a, d);
        chk(name, d, exp);
    endtask

    initial begin
        vecs[0]  = '{0, A_PEND,       16'h0000, 16'h0000, "rst_pend"};
        vecs[1]  = '{0, A_EN,         16'h0000, 16'h0000, "rst_en"};
        vecs[2]  = '{0, A_EDGE,       16'h0000, 16'h0000, "rst_edge"};
        vecs[3]  = '{0, A_CAUSE,      16'h0000, 16'h0000, "rst_cause"};
        vecs[4]  = '{1, A_EN,         16'h015A, 16'h0000, "wr_en"};
        vecs[5]  = '{0, A_EN,         16'h0000, 16'h005A, "rd_en"};
        vecs[6]  = '{1, A_EDGE,       16'hFF80, 16'h0000, "wr_edge"};
        vecs[7]  = '{0, 16'h0105,     16'h0000, 16'h0080, "rd_edge_a0"};
        vecs[8]  = '{1, A_EN,         16'h0000, 16'h0000, "wr_en0"};
        vecs[9]  = '{1, A_FORCE,      16'h00FF, 16'h0000, "force"};
        vecs[10] = '{0, A_PEND,       16'h0000, 16'h0080, "rd_pend_force"};
        vecs[11] = '{0, A_CAUSE,      16'h0000, 16'h0000, "cause_masked"};
        vecs[12] = '{0, 16'h010A,     16'h0000, 16'h0000, "rd_unmapped"};
        vecs[13] = '{0, 16'h0200,     16'h0000, 16'h0000, "rd_nonbase"};
        vecs[14] = '{0, A_FORCE,      16'h0000, 16'h0000, "rd_force"};

        resetq   = 1'b0;
        irq_src  = 8'h00;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = 16'h0;
        io_wdata = 16'h0;

        // Reset held with sources toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            irq_src = (i % 2 == 0) ? 8'hFF : 8'h00;
        end
        chk("rst_irq", 16'(interrupt_request), 16'h0);
        io_rd   = 1'b1;
        io_addr = A_PEND;
        #1 chk("rst_rd_pend", io_rdata, 16'h0000);
        io_rd   = 1'b0;
        @(negedge clk);
        resetq  = 1'b1;
        irq_src = 8'h00;
        repeat (4) @(negedge clk);
        chk("post_rst_irq", 16'(interrupt_request), 16'h0);

        // Register table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                io_write(vecs[i].addr, vecs[i].data);
            end else begin
                rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
            end
            chk({vecs[i].name, "_irq"}, 16'(interrupt_request), 16'h0);
        end

        // Masked pending becomes visible when enabled
        io_write(A_EN, 16'h0080);
        chk("unmask_irq_k", 16'(interrupt_request), 16'h0);
        @(negedge clk);
        chk("unmask_irq_k1", 16'(interrupt_request), 16'h1);
        rd_chk("cause7", A_CAUSE, 16'h8007);
        @(negedge clk);
        chk("cause7_irq_low", 16'(interrupt_request), 16'h0);
        rd_chk("cause7_pend", A_PEND, 16'h0000);

        // Edge latency
        io_write(A_EN, 16'h0004);
        io_write(A_EDGE, 16'h0004);
        irq_src = 8'h04;
        repeat (3) @(negedge clk);
        chk("lat_e3", 16'(interrupt_request), 16'h0);
        irq_src = 8'h00;
        @(negedge clk);
        chk("lat_e4", 16'(interrupt_request), 16'h1);
        rd_chk("lat_cause", A_CAUSE, 16'h8002);
        chk("lat_irq_k", 16'(interrupt_request), 16'h1);
        @(negedge clk);
        chk("lat_irq_k1", 16'(interrupt_request), 16'h0);
        rd_chk("lat_pend", A_PEND, 16'h0000);

        // Priority
        io_write(A_EDGE, 16'h00FF);
        io_write(A_EN, 16'h00FF);
        irq_src = 8'h22;
        repeat (4) @(negedge clk);
        chk("prio_irq", 16'(interrupt_request), 16'h1);
        rd_chk("prio_c1", A_CAUSE, 16'h8001);
        rd_chk("prio_c2", A_CAUSE, 16'h8005);
        rd_chk("prio_c3", A_CAUSE, 16'h0000);
        irq_src = 8'h00;
        repeat (3) @(negedge clk);

        // Level mode
        io_write(A_EDGE, 16'h0000);
        io_write(A_EN, 16'h0001);
        irq_src = 8'h01;
        repeat (4) @(negedge clk);
        chk("lvl_irq", 16'(interrupt_request), 16'h1);
        rd_chk("lvl_c1", A_CAUSE, 16'h8000);
        rd_chk("lvl_c2", A_CAUSE, 16'h8000);
        io_write(A_PEND, 16'h0001);
        rd_chk("lvl_w1c", A_PEND, 16'h0001);
        irq_src = 8'h00;
        repeat (3) @(negedge clk);
        rd_chk("lvl_drop", A_PEND, 16'h0000);
        chk("lvl_irq_low", 16'(interrupt_request), 16'h0);

        // Set-vs-clear race
        io_write(A_EDGE, 16'h0008);
        io_write(A_EN, 16'h0000);
        io_write(A_FORCE, 16'h0008);
        rd_chk("race_pre", A_PEND, 16'h0008);
        irq_src = 8'h08;
        repeat (2) @(negedge clk);
        io_write(A_PEND, 16'h0008);
        rd_chk("race_set_wins", A_PEND, 16'h0008);
        io_write(A_PEND, 16'h0008);
        rd_chk("race_w1c", A_PEND, 16'h0000);
        irq_src = 8'h00;

        // Async reset mid-operation
        io_write(A_FORCE, 16'h0008);
        io_write(A_EN, 16'h0008);
        @(negedge clk);
        chk("mid_irq", 16'(interrupt_request), 16'h1);
        #2 resetq = 1'b0;
        #1 chk("mid_rst_irq", 16'(interrupt_request), 16'h0);
        io_rd   = 1'b1;
        io_addr = A_EN;
        #1 chk("mid_rst_en", io_rdata, 16'h0000);
        io_rd   = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        rd_chk("mid_rst_pend", A_PEND, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
